// File: rtl/id_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_issue_ctrl_pkg
//   Shared definitions for the decode-stage issue/hazard controller:
//   default widths and the drain FSM state encoding.
// -----------------------------------------------------------------------------
package id_issue_ctrl_pkg;

  // Register address width (2**REG_LOG architectural registers, r0 = zero).
  localparam int REG_LOG_DEF = 5;
  // Per-register in-flight write counter width.
  localparam int CNT_W_DEF   = 2;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/id_issue_ctrl_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   Per-register count of register-file writes that have issued but not yet
//   written back. r0 is never counted.
//
//   Optional feature macro: ID_BYPASS_EN
//     defined   : a register with exactly one pending write that is being
//                 written back this cycle is not reported as blocking
//                 (the RF supplies write-first reads).
//     undefined : any non-zero count blocks readers.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   inc_en/inc_rd  count one more pending write to inc_rd
//   dec_en/dec_rd  writeback retires one pending write of dec_rd
//   blocking       per register: a reader must wait this cycle
//   full           per register: counter saturated
//   all_zero_next  every counter is zero after this edge's update
//   err            sticky: writeback seen for a register with count 0
// -----------------------------------------------------------------------------
module reg_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_LOG = REG_LOG_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_en,
  input  logic [REG_LOG-1:0]    inc_rd,
  input  logic                  dec_en,
  input  logic [REG_LOG-1:0]    dec_rd,
  output logic [2**REG_LOG-1:0] blocking,
  output logic [2**REG_LOG-1:0] full,
  output logic                  all_zero_next,
  output logic                  err
);

  localparam int               NREG    = 2**REG_LOG;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic             err_set;

  // One-hot increment/decrement requests. A decrement of an empty counter
  // is dropped (count stays 0) and flagged instead.
  // NOTE: every variable driven in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    err_set = 1'b0;
    if (inc_en && inc_rd != '0) inc_vec[inc_rd] = 1'b1;
    if (dec_en && dec_rd != '0) begin
      if (cnt_q[dec_rd] != '0) dec_vec[dec_rd] = 1'b1;
      else                     err_set         = 1'b1;
    end
  end

  // Next counts; simultaneous inc and dec of the same register cancel.
  always_comb begin
    all_zero_next = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r])      cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec_vec[r] && !inc_vec[r]) cnt_d[r] = cnt_q[r] - CNT_ONE;
      if (cnt_d[r] != '0) all_zero_next = 1'b0;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      full[r]     = (cnt_q[r] == CNT_MAX);
      blocking[r] = (cnt_q[r] != '0);
`ifdef ID_BYPASS_EN
      // Last pending write lands this cycle: the RF forwards it.
      if (cnt_q[r] == CNT_ONE && dec_vec[r]) blocking[r] = 1'b0;
`endif
    end
  end

  // NOTE: the counter array is cleared by reset on purpose: pending-write
  // state left over from before reset would stall or mis-flag forever.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// id_issue_ctrl
//   Decode-stage issue/hazard controller. Decides in the same cycle whether
//   the instruction held in ID may issue to EX, stalls on RAW hazards and on
//   pending-write counter saturation, and drains the pipe on request.
//
//   Optional feature macro: ID_BYPASS_EN (see reg_scoreboard) -- a source
//   whose last pending write is written back this cycle does not stall.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   id_valid     ID holds a decoded instruction
//   id_rs        {rs2, rs1, rs0} source addresses
//   id_ren       read enable per source (bit i <-> rs_i)
//   id_wen/id_rd instruction writes register id_rd
//   ex_ready     EX accepts an instruction this cycle
//   flush        kill the ID instruction this cycle
//   wb_valid/wb_rd  register-file writeback this cycle
//   drain_req    request an empty pipeline
//   issue        ID instruction accepted by EX this cycle
//   id_stall     hold IF/ID this cycle
//   drain_done   no pending writes; held while draining is complete
//   sb_err       sticky: writeback to a register with no pending write
// -----------------------------------------------------------------------------
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int REG_LOG = REG_LOG_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [3*REG_LOG-1:0] id_rs,
  input  logic [2:0]           id_ren,
  input  logic                 id_wen,
  input  logic [REG_LOG-1:0]   id_rd,
  input  logic                 ex_ready,
  input  logic                 flush,
  input  logic                 wb_valid,
  input  logic [REG_LOG-1:0]   wb_rd,
  input  logic                 drain_req,
  output logic                 issue,
  output logic                 id_stall,
  output logic                 drain_done,
  output logic                 sb_err
);

  localparam int NREG = 2**REG_LOG;

  drain_state_e      state_q, state_d;
  logic [NREG-1:0]   blocking;
  logic [NREG-1:0]   full;
  logic              all_zero_next;
  logic              raw;
  logic              sat;

  reg_scoreboard #(
    .REG_LOG (REG_LOG),
    .CNT_W   (CNT_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .inc_en        (issue & id_wen),
    .inc_rd        (id_rd),
    .dec_en        (wb_valid),
    .dec_rd        (wb_rd),
    .blocking      (blocking),
    .full          (full),
    .all_zero_next (all_zero_next),
    .err           (sb_err)
  );

  // RAW: any enabled source with an outstanding write. r0 is never blocking.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (id_ren[i] && blocking[id_rs[i*REG_LOG +: REG_LOG]]) raw = 1'b1;
    end
  end

  assign sat = id_wen && (id_rd != '0) && full[id_rd];

  assign issue = !rst && id_valid && !raw && !sat && ex_ready && !flush &&
                 (state_q == S_RUN) && !drain_req;

  // A flushed instruction is dead: neither issued nor held.
  assign id_stall   = !rst && id_valid && !issue && !flush;
  assign drain_done = !rst && (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (drain_req) state_d = S_DRAIN;
      // Dropping the request abandons the drain; completion looks at the
      // counts as they will be after this edge's writeback.
      S_DRAIN: if (!drain_req)        state_d = S_RUN;
               else if (all_zero_next) state_d = S_DONE;
      S_DONE:  if (!drain_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

`ifdef ID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [14:0] id_rs;
  logic [2:0]  id_ren;
  logic        id_wen;
  logic [4:0]  id_rd;
  logic        ex_ready;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        drain_req;
  logic        issue;
  logic        id_stall;
  logic        drain_done;
  logic        sb_err;

  int n_checks = 0;
  int n_errors = 0;

  id_issue_ctrl #(.REG_LOG(5), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_ren     (id_ren),
    .id_wen     (id_wen),
    .id_rd      (id_rd),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .drain_req  (drain_req),
    .issue      (issue),
    .id_stall   (id_stall),
    .drain_done (drain_done),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs = '0; id_ren = '0; id_wen = 1'b0; id_rd = '0;
    ex_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
  endtask

  // One instruction in ID: ren bit i enables rs_i.
  task automatic instr(input logic [2:0] ren, input logic [4:0] rs2, input logic [4:0] rs1,
                       input logic [4:0] rs0, input logic wen, input logic [4:0] rd);
    id_valid = 1'b1; id_ren = ren; id_rs = {rs2, rs1, rs0}; id_wen = wen; id_rd = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid = v; wb_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_io(input string tag, input logic exp_issue, input logic exp_stall);
    #1;
    check({tag, ".issue"}, 32'(issue), 32'(exp_issue));
    check({tag, ".stall"}, 32'(id_stall), 32'(exp_stall));
  endtask

  initial begin
    // ---- reset ----
    idle(); drain_req = 1'b0; rst = 1'b1;
    instr(3'b000, 0, 0, 0, 1'b0, 0);
    tick(); tick();
    chk_io("rst", 1'b0, 1'b0);
    check("rst.drain_done", 32'(drain_done), 0);
    check("rst.sb_err", 32'(sb_err), 0);
    rst = 1'b0;
    chk_io("rst_rel", 1'b1, 1'b0);
    ex_ready = 1'b0;
    chk_io("ex_busy", 1'b0, 1'b1);
    tick(); idle();

    // ---- 1: RAW on r5 ----
    instr(3'b000, 0, 0, 0, 1'b1, 5'd5);
    chk_io("t1.wr5", 1'b1, 1'b0);
    tick();
    instr(3'b001, 0, 0, 5'd5, 1'b0, 0);
    chk_io("t1.raw_a", 1'b0, 1'b1);
    tick();
    instr(3'b010, 0, 5'd5, 0, 1'b0, 0);   // same hazard via rs1
    chk_io("t1.raw_b", 1'b0, 1'b1);
    tick();
    wb(1'b1, 5'd5);
    chk_io("t1.wb_cyc", BYP, !BYP);
    tick(); wb(1'b0, 0);
    chk_io("t1.after_wb", 1'b1, 1'b0);
    tick(); idle();

    // ---- 2: WAW saturation on r7 ----
    for (int k = 0; k < 3; k++) begin
      instr(3'b000, 0, 0, 0, 1'b1, 5'd7);
      chk_io($sformatf("t2.w%0d", k), 1'b1, 1'b0);
      tick();
    end
    chk_io("t2.sat", 1'b0, 1'b1);
    wb(1'b1, 5'd7);
    chk_io("t2.sat_wb", 1'b0, 1'b1);
    tick(); wb(1'b0, 0);
    chk_io("t2.w4", 1'b1, 1'b0);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      wb(1'b1, 5'd7); tick();
    end
    idle();
    instr(3'b100, 5'd7, 0, 0, 1'b0, 0);
    chk_io("t2.r7_clear", 1'b1, 1'b0);
    tick(); idle();

    // ---- 3: issue and wb of r9 in the same cycle ----
    instr(3'b000, 0, 0, 0, 1'b1, 5'd9);
    chk_io("t3.w1", 1'b1, 1'b0);
    tick();
    wb(1'b1, 5'd9);
    chk_io("t3.w2_wb", 1'b1, 1'b0);
    tick(); wb(1'b0, 0);
    instr(3'b001, 0, 0, 5'd9, 1'b0, 0);
    chk_io("t3.still_busy", 1'b0, 1'b1);
    tick();
    idle(); wb(1'b1, 5'd9); tick(); wb(1'b0, 0);
    instr(3'b001, 0, 0, 5'd9, 1'b0, 0);
    chk_io("t3.cnt_was_1", 1'b1, 1'b0);
    tick(); idle();

    // ---- 4: flush and r0 ----
    instr(3'b000, 0, 0, 0, 1'b1, 5'd4);
    tick();
    instr(3'b001, 0, 0, 5'd4, 1'b1, 5'd6);
    flush = 1'b1;
    chk_io("t4.flush", 1'b0, 1'b0);
    tick(); flush = 1'b0;
    instr(3'b001, 0, 0, 5'd6, 1'b0, 0);
    chk_io("t4.r6_untouched", 1'b1, 1'b0);
    tick();
    instr(3'b000, 0, 0, 0, 1'b1, 5'd0);
    chk_io("t4.wr0", 1'b1, 1'b0);
    tick();
    instr(3'b111, 0, 0, 0, 1'b0, 0);
    wb(1'b1, 5'd0);
    chk_io("t4.rd_r0", 1'b1, 1'b0);
    tick(); idle();
    check("t4.sb_err_r0", 32'(sb_err), 0);
    wb(1'b1, 5'd4); tick(); idle();
    check("t4.sb_err_r4", 32'(sb_err), 0);

    // ---- 5: drain ----
    instr(3'b000, 0, 0, 0, 1'b1, 5'd10); tick();
    instr(3'b000, 0, 0, 0, 1'b1, 5'd11); tick();
    instr(3'b001, 0, 0, 5'd1, 1'b0, 0);
    drain_req = 1'b1;
    chk_io("t5.req", 1'b0, 1'b1);
    check("t5.done0", 32'(drain_done), 0);
    tick();
    wb(1'b1, 5'd10);
    chk_io("t5.drain", 1'b0, 1'b1);
    check("t5.done1", 32'(drain_done), 0);
    tick();
    wb(1'b1, 5'd11);
    #1 check("t5.done2", 32'(drain_done), 0);
    tick(); wb(1'b0, 0);
    chk_io("t5.in_done", 1'b0, 1'b1);
    check("t5.done3", 32'(drain_done), 1);
    tick();
    check("t5.done_hold", 32'(drain_done), 1);
    drain_req = 1'b0;
    chk_io("t5.drop", 1'b0, 1'b1);
    tick();
    chk_io("t5.run", 1'b1, 1'b0);
    check("t5.done_clr", 32'(drain_done), 0);
    tick(); idle();

    // ---- 6: sb_err, reset mid-drain ----
    wb(1'b1, 5'd3); tick(); idle();
    check("t6.err", 32'(sb_err), 1);
    tick(); tick();
    check("t6.err_sticky", 32'(sb_err), 1);
    instr(3'b000, 0, 0, 0, 1'b1, 5'd12); tick(); idle();
    drain_req = 1'b1; tick(); tick();
    check("t6.draining", 32'(drain_done), 0);
    rst = 1'b1;
    instr(3'b001, 0, 0, 5'd12, 1'b0, 0);
    chk_io("t6.in_rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0; drain_req = 1'b0;
    chk_io("t6.post_rst", 1'b1, 1'b0);
    check("t6.err_clr", 32'(sb_err), 0);
    check("t6.done_clr", 32'(drain_done), 0);
    tick(); idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
